// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared configuration for the HDMI data-island scheduler: 720p line geometry,
// island segment lengths, phase/state encodings and requester indices.
package hdmi_island_scheduler_pkg;

  localparam int VIDEO_X_BITWIDTH = 11;
  localparam int VIDEO_Y_BITWIDTH = 10;
  localparam int SCREENWIDTH      = 1280;
  localparam int TOTALWIDTH       = 1650;

  localparam int ISLAND_START = SCREENWIDTH + 12;
  localparam int MAX_PACKETS  = 2;
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  localparam int REQ_ACR   = 0;
  localparam int REQ_AUDIO = 1;
  localparam int REQ_AVI   = 2;
  localparam int REQ_AIF   = 3;

  typedef enum logic [1:0] {
    PH_CTRL     = 2'd0,
    PH_PREAMBLE = 2'd1,
    PH_GUARD    = 2'd2,
    PH_DATA     = 2'd3
  } island_phase_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_LEAD_GUARD,
    ST_DATA,
    ST_TRAIL_GUARD
  } state_e;

  // The whole island (preamble, both guards, all packets) must end 12 pixels before line end.
  function automatic bit island_fits(int start, int max_pkts);
    return (start + PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN * max_pkts) <= (TOTALWIDTH - 12);
  endfunction

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// Timing/requester side <-> island scheduler signal bundle.
interface hdmi_island_scheduler_if
  import hdmi_island_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic                        enable;
  logic [VIDEO_X_BITWIDTH-1:0] cx;
  logic [VIDEO_Y_BITWIDTH-1:0] cy;
  logic [NUM_REQ-1:0]          req;
  island_phase_e               island_phase;
  logic [NUM_REQ-1:0]          grant;
  logic                        null_pkt;
  logic [4:0]                  pkt_idx;
  logic                        pkt_start;
  logic                        pkt_last;

  modport master (
    output enable, cx, cy, req,
    input  island_phase, grant, null_pkt, pkt_idx, pkt_start, pkt_last
  );

  modport slave (
    input  enable, cx, cy, req,
    output island_phase, grant, null_pkt, pkt_idx, pkt_start, pkt_last
  );
endinterface

// File: rtl/hdmi_island_scheduler_prio_arbiter.sv
// Fixed-priority picker: lowest-indexed request not blocked by the mask wins.
module hdmi_island_scheduler_prio_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] gnt_o
);
  logic [N-1:0] eligible;

  assign eligible = req_i & ~mask_i;
  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o    = eligible & (~eligible + N'(1));
endmodule

// File: rtl/hdmi_island_scheduler.sv
// Schedules one HDMI data island per line: preamble, leading guard, up to
// MAX_PACKETS arbitrated 32-cycle packets, trailing guard.
module hdmi_island_scheduler
  import hdmi_island_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PACKETS  = hdmi_island_scheduler_pkg::MAX_PACKETS,
  parameter int ISLAND_START = hdmi_island_scheduler_pkg::ISLAND_START
) (
  input  logic                    clk_pixel,
  input  logic                    rst_n,
  hdmi_island_scheduler_if.slave  bus
);
  localparam int X_W    = VIDEO_X_BITWIDTH;
  localparam int PCNT_W = $clog2(MAX_PACKETS + 1);

  if (!island_fits(ISLAND_START, MAX_PACKETS)) begin : g_fit_err
    $error("data island would overrun the horizontal line");
  end

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                armed_q, armed_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                null_q, null_d;
  island_phase_e       phase_q, phase_d;
  logic [4:0]          idx_q, idx_d;
  logic                start_q, start_d;
  logic                last_q, last_d;
  logic [NUM_REQ-1:0]  arb_mask, arb_gnt;
  logic                unused_cy;

  // Islands run on every line, so the line number never gates anything.
  assign unused_cy = ^bus.cy;

  // Outside DATA the mask is zero; inside it blocks the packet just finishing.
  assign arb_mask = (state_q == ST_DATA) ? gnt_q : '0;

  hdmi_island_scheduler_prio_arbiter #(.N(NUM_REQ)) u_prio_arbiter (
    .req_i  (bus.req),
    .mask_i (arb_mask),
    .gnt_o  (arb_gnt)
  );

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      armed_q <= 1'b1;
      gnt_q   <= '0;
      null_q  <= 1'b0;
      phase_q <= PH_CTRL;
      idx_q   <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      armed_q <= armed_d;
      gnt_q   <= gnt_d;
      null_q  <= null_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    pcnt_d  = pcnt_q;
    armed_d = armed_q;
    gnt_d   = gnt_q;
    null_d  = null_q;
    if (bus.cx == '0) armed_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        pcnt_d = '0;
        // One decision point per line; disarm even when no island starts.
        if (bus.cx == X_W'(ISLAND_START - 1)) begin
          armed_d = 1'b0;
          if (armed_q && bus.enable && (|bus.req)) state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == 5'(PREAMBLE_LEN - 1)) begin
          state_d = ST_LEAD_GUARD;
          cnt_d   = '0;
        end
      end
      ST_LEAD_GUARD: begin
        if (cnt_q == 5'(GUARD_LEN - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          gnt_d   = arb_gnt;
          null_d  = ~(|arb_gnt);
          pcnt_d  = PCNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == 5'(PACKET_LEN - 1)) begin
          cnt_d = '0;
          if ((pcnt_q < PCNT_W'(MAX_PACKETS)) && (|arb_gnt)) begin
            gnt_d  = arb_gnt;
            null_d = 1'b0;
            pcnt_d = pcnt_q + PCNT_W'(1);
          end else begin
            state_d = ST_TRAIL_GUARD;
            gnt_d   = '0;
            null_d  = 1'b0;
          end
        end
      end
      ST_TRAIL_GUARD: begin
        if (cnt_q == 5'(GUARD_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d = PH_CTRL;
    idx_d   = '0;
    start_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_d)
      ST_PREAMBLE:                   phase_d = PH_PREAMBLE;
      ST_LEAD_GUARD, ST_TRAIL_GUARD: phase_d = PH_GUARD;
      ST_DATA: begin
        phase_d = PH_DATA;
        idx_d   = cnt_d;
        start_d = (cnt_d == 5'd0);
        last_d  = (cnt_d == 5'(PACKET_LEN - 1));
      end
      default: phase_d = PH_CTRL;
    endcase
  end

  assign bus.island_phase = phase_q;
  assign bus.grant        = gnt_q;
  assign bus.null_pkt     = null_q;
  assign bus.pkt_idx      = idx_q;
  assign bus.pkt_start    = start_q;
  assign bus.pkt_last     = last_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for the HDMI island scheduler on a 720p line (1650 clocks).
module tb_hdmi_island_scheduler;
  import hdmi_island_scheduler_pkg::*;

  localparam int TOTAL = 1650;

  logic clk_pixel = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  int         exp_npk;
  logic [3:0] exp_g0, exp_g1;
  logic       exp_null0;
  int         chg_cx;
  logic [3:0] chg_val;
  bit         ack_drop;
  logic [3:0] drop_pend;

  hdmi_island_scheduler_if #(.NUM_REQ(4)) bus ();

  hdmi_island_scheduler #(
    .NUM_REQ      (4),
    .MAX_PACKETS  (2),
    .ISLAND_START (1292)
  ) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cx=%0d observed=%0h expected=%0h", tag, bus.cx, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_phase"}, 32'(bus.island_phase), 32'd0);
    chk({pfx, "_grant"}, 32'(bus.grant),        32'd0);
    chk({pfx, "_null"},  32'(bus.null_pkt),     32'd0);
    chk({pfx, "_idx"},   32'(bus.pkt_idx),      32'd0);
    chk({pfx, "_start"}, 32'(bus.pkt_start),    32'd0);
    chk({pfx, "_last"},  32'(bus.pkt_last),     32'd0);
  endtask

  // Advance the timing generator by one pixel; requesters retire acknowledged bits.
  task automatic tick();
    @(negedge clk_pixel);
    if (bus.cx == 11'(TOTAL - 1)) begin
      bus.cx = '0;
      bus.cy = bus.cy + 10'd1;
    end else begin
      bus.cx = bus.cx + 11'd1;
    end
    if (ack_drop) bus.req = bus.req & ~drop_pend;
    if (int'(bus.cx) == chg_cx) bus.req = chg_val;
    drop_pend = bus.grant & {4{bus.pkt_last}};
  endtask

  task automatic check_cycle();
    int c;
    int e_ph;
    logic [3:0] e_g;
    logic e_n, e_s, e_l;
    int e_idx, dend, k;
    c = int'(bus.cx);
    e_ph = 0; e_g = '0; e_n = 1'b0; e_s = 1'b0; e_l = 1'b0; e_idx = 0;
    if (!((c < 4) || (c >= 1280 && c <= 1380))) return;
    if (exp_npk > 0) begin
      dend = 1302 + 32 * exp_npk;
      if (c >= 1292 && c < 1300) e_ph = 1;
      else if (c >= 1300 && c < 1302) e_ph = 2;
      else if (c >= 1302 && c < dend) begin
        e_ph  = 3;
        k     = (c - 1302) / 32;
        e_idx = (c - 1302) % 32;
        e_g   = (k == 0) ? exp_g0 : exp_g1;
        e_n   = (k == 0) ? exp_null0 : 1'b0;
        e_s   = (e_idx == 0);
        e_l   = (e_idx == 31);
      end else if (c >= dend && c < dend + 2) e_ph = 2;
    end
    chk("phase", 32'(bus.island_phase), 32'(e_ph));
    chk("grant", 32'(bus.grant),        32'(e_g));
    chk("null",  32'(bus.null_pkt),     32'(e_n));
    chk("idx",   32'(bus.pkt_idx),      32'(e_idx));
    chk("start", 32'(bus.pkt_start),    32'(e_s));
    chk("last",  32'(bus.pkt_last),     32'(e_l));
  endtask

  task automatic run_until(input int stop);
    do begin
      check_cycle();
      tick();
    end while (int'(bus.cx) != stop);
  endtask

  task automatic set_line(input int npk, input logic [3:0] g0, input logic [3:0] g1, input logic n0);
    exp_npk   = npk;
    exp_g0    = g0;
    exp_g1    = g1;
    exp_null0 = n0;
    chg_cx    = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.cx = '0;
    bus.cy = '0;
    bus.req = '0;
    ack_drop = 1'b0;
    drop_pend = '0;
    chg_val = '0;
    set_line(0, 4'b0000, 4'b0000, 1'b0);

    repeat (3) @(negedge clk_pixel);
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Single steady requester: one packet, self-masked on pkt_last.
    bus.req = 4'b1 << REQ_AUDIO;
    set_line(1, 4'b0010, 4'b0000, 1'b0);
    run_until(0);

    // ACR then AVI in one island; requesters drop bits after acknowledge.
    ack_drop = 1'b1;
    bus.req = (4'b1 << REQ_ACR) | (4'b1 << REQ_AVI);
    set_line(2, 4'b0001, 4'b0100, 1'b0);
    run_until(0);

    // All four pending: two per island, leftovers served next line.
    bus.req = 4'b1111;
    set_line(2, 4'b0001, 4'b0010, 1'b0);
    run_until(0);
    set_line(2, 4'b0100, 4'b1 << REQ_AIF, 1'b0);
    run_until(0);

    // Nothing requested at the decision point: no island this line.
    bus.req = 4'b0000;
    set_line(0, 4'b0000, 4'b0000, 1'b0);
    run_until(0);

    // Request withdrawn during preamble: a null packet fills the slot.
    bus.req = 4'b0001;
    set_line(1, 4'b0000, 4'b0000, 1'b1);
    chg_cx = 1295;
    chg_val = 4'b0000;
    run_until(0);

    // Asynchronous reset in the middle of DATA.
    ack_drop = 1'b0;
    bus.req = 4'b0010;
    set_line(1, 4'b0010, 4'b0000, 1'b0);
    run_until(1310);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    set_line(0, 4'b0000, 4'b0000, 1'b0);
    run_until(0);
    set_line(1, 4'b0010, 4'b0000, 1'b0);
    run_until(0);

    // Disabled: no islands despite a pending request.
    bus.enable = 1'b0;
    bus.req = 4'b1 << REQ_ACR;
    set_line(0, 4'b0000, 4'b0000, 1'b0);
    run_until(0);
    run_until(0);
    bus.enable = 1'b1;
    set_line(1, 4'b0001, 4'b0000, 1'b0);
    run_until(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
